// File: rtl/fpu_result_wb.sv
// fpu_result_wb: FMA writeback FIFO with binary32 packing, sticky fflags and retired-op counter.
// Optional: define FPU_WB_CANON_NAN_EN to canonicalise NaNs to 32'h7FC00000 at push.
module fpu_result_wb #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [23:0]      in_mantissa,
  input  logic             in_inexact,
  input  logic             in_invalid,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic             in_infinite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  output logic             out_inf,
  output logic [4:0]       fflags,
  input  logic             fflags_wr,
  input  logic [4:0]       fflags_wdata,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] ops_count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem_data  [DEPTH];
  logic [4:0]    mem_flags [DEPTH];
  logic          mem_inf   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [31:0]   wdata;
  assign in_ready  = count < (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_flags = mem_flags[rd_ptr];
  assign out_inf   = mem_inf[rd_ptr];
`ifdef FPU_WB_CANON_NAN_EN
  assign wdata = (in_exp == 8'hFF && |in_mantissa[22:0]) ? 32'h7FC0_0000 : {in_sign, in_exp, in_mantissa[22:0]};
`else
  assign wdata = {in_sign, in_exp, in_mantissa[22:0]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_flags[i] <= '0;
        mem_inf[i]   <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fflags    <= '0;
      ops_count <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= wdata;
        mem_flags[wr_ptr] <= {in_invalid, 1'b0, in_overflow, in_underflow, in_inexact};
        mem_inf[wr_ptr]   <= in_infinite;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // retiring flags are OR-ed after the CSR write/clear so they are never lost
      fflags    <= (fflags_wr ? fflags_wdata : fflags_clr ? 5'b0 : fflags) | (pop ? out_flags : 5'b0);
      ops_count <= ops_count + {{(CNT_W-1){1'b0}}, pop};
    end
  end
endmodule

// File: doc/fpu_result_wb.md
Name: fpu_result_wb

Overview:
Writeback stage directly downstream of the combinational FMA datapath (multiplier → adder → rounding). It captures each rounded result and its exception bits through a valid/ready handshake into a small FIFO. It packs the result into an IEEE-754 binary32 word and presents it to the register-file write port. It also maintains RISC-V-style sticky accrued flags (fflags) and a count of retired operations.

Parameters:
DEPTH, 2, FIFO entries; power of two, ≥2
CNT_W, 16, width of retired-operation counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  FMA result valid
in_ready  output  1  stage can accept (count < DEPTH)
in_sign  input  1  rounded sign
in_exp  input  8  rounded biased exponent
in_mantissa  input  24  rounded significand; bit 23 = hidden bit, [22:0] = fraction
in_inexact  input  1  NX from FMA
in_invalid  input  1  NV from FMA
in_overflow  input  1  OF from FMA
in_underflow  input  1  UF from FMA
in_infinite  input  1  infinity produced (status only, not an fflag)
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_data  output  32  {sign, exp, mantissa[22:0]} of head entry
out_flags  output  5  head entry flags {NV,DZ,OF,UF,NX}
out_inf  output  1  head entry in_infinite
fflags  output  5  sticky accrued flags {NV,DZ,OF,UF,NX}
fflags_wr  input  1  CSR write of fflags
fflags_wdata  input  5  CSR write data
fflags_clr  input  1  clear fflags
ops_count  output  CNT_W  retired-operation counter

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty; read/write pointers and count are 0; out_valid=0; out_data=0; out_flags=0; out_inf=0; fflags=0; ops_count=0; in_ready=1 once reset is released.
- Push when in_valid & in_ready: write the packed word {in_sign, in_exp, in_mantissa[22:0]}, flags {in_invalid, 1'b0, in_overflow, in_underflow, in_inexact}, and in_infinite at the write pointer.
- The DZ bit is hardwired to 0, because the FMA cannot divide by zero.
- Pop when out_valid & out_ready: advance the read pointer.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency: data pushed in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. There is no combinational in→out path.
- Full: in_ready=0, even if out_ready=1 in the same cycle; there is no full-bypass. in_ready depends only on registered count.
- Empty: out_valid=0. out_data/out_flags/out_inf hold the last read-pointer entry contents and are don't-care to the consumer.
- Flags accrue at retirement, not at push. commit = out_valid & out_ready.
- fflags_next = (fflags_wr ? fflags_wdata : fflags_clr ? 5'b0 : fflags) | (commit ? out_flags : 5'b0).
- fflags_wr has priority over fflags_clr.
- Flags of an operation retiring in the same cycle as a write or clear are never lost.
- ops_count increments by 1 on each commit and wraps from 2^CNT_W−1 to 0. It is unaffected by fflags_wr/fflags_clr.
- in_* signals are sampled only on push; values while in_ready=0 are ignored.
- Reset mid-operation: all buffered entries are discarded and no flags are accrued.

Optional Feature:
Macro FPU_WB_CANON_NAN_EN.
- Defined: at push, if in_exp==8'hFF and in_mantissa[22:0]!=0, the stored word is forced to 32'h7FC00000 (canonical quiet NaN). The sign and payload of the incoming NaN are discarded; flags are stored unchanged.
- Not defined: NaNs pass through bit-exact as {in_sign, 8'hFF, in_mantissa[22:0]}.

Test Plan:
- Reset, then push sign=0, exp=8'h7F, mant=24'h800000 with out_ready=1 → next cycle out_valid=1, out_data=32'h3F800000, out_flags=0; after pop, ops_count=1 and fflags=0.
- Hold out_ready=0 and push 3 results back-to-back (DEPTH=2) → in_ready=0 after 2 pushes, the 3rd is not accepted until a pop; entries drain in order.
- Push an overflow result (exp=8'hFF, mant=24'h800000, OF=1, NX=1, inf=1) and pop it → out_data=32'h7F800000, out_inf=1, fflags=5'b00101.
- In one cycle, commit an entry with NV=1 while fflags_clr=1 → fflags=5'b10000. In the next cycle, fflags_wr=1 with wdata=5'b00001 and no commit → fflags=5'b00001.
- Push a NaN with sign=1, exp=8'hFF, mant=24'hC12345 → with FPU_WB_CANON_NAN_EN, out_data=32'h7FC00000; without it, out_data=32'hFFC12345.
- With CNT_W=4, retire 17 operations, and assert rst_n low while 1 entry is buffered → ops_count reads 1 before the reset; after reset, out_valid=0, fflags=0, ops_count=0.
